// File: rtl/dbg_scan_480.sv
// Debug-view sequencer: display tick divider, per-channel entry scan through a
// request/acknowledge read port, and frame-ROM animation playback.
module dbg_scan_480 #(
    parameter int NCH      = 4,
    parameter int AW       = 5,
    parameter int FRAMES   = 48,
    parameter int FW       = 6,
    parameter int DIV_FAST = 24,
    parameter int DIV_SLOW = 27,
    parameter int TMO      = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic              slow,
    input  logic              anim_en,
    input  logic [3:0]        ch_sel,
    input  logic [NCH*AW-1:0] ch_depth,
    input  logic              clr_ptr,
    output logic              rd_req,
    output logic [3:0]        rd_ch,
    output logic [AW-1:0]     rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    output logic [FW-1:0]     frame_addr,
    input  logic [63:0]       frame_data,
    output logic              tick,
    output logic [63:0]       disp_data,
    output logic              disp_upd
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [31:0]   MASK_FAST = 32'((64'd1 << DIV_FAST) - 64'd1);
    localparam logic [31:0]   MASK_SLOW = 32'((64'd1 << DIV_SLOW) - 64'd1);
    localparam logic [TW-1:0] WLAST     = TW'(TMO - 1);
    localparam logic [FW-1:0] FLAST     = FW'(FRAMES - 1);
    localparam logic [31:0]   TMO_DATA  = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [31:0]   cnt_nxt;
    logic [31:0]   div_mask;
    logic [3:0]    ch_clamp;
    logic [AW-1:0] depth_m1 [NCH];
    logic [AW-1:0] ptr [NCH];
    logic [FW-1:0] fidx;
    logic [TW-1:0] wcnt;
    logic [31:0]   data_q;
    logic          discard;
    logic [CW-1:0] cur;

    assign frame_addr = fidx;
    assign cur        = rd_ch[CW-1:0];
    assign cnt_nxt    = cnt + 32'd1;
    assign div_mask   = slow ? MASK_SLOW : MASK_FAST;

    always_comb begin
        ch_clamp = ch_sel;
        if ({1'b0, ch_sel} >= 5'(NCH)) begin
            ch_clamp = 4'(NCH - 1);
        end
    end

    // A depth of zero behaves like a single-entry channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            depth_m1[i] = (ch_depth[i*AW +: AW] == '0) ? '0 : ch_depth[i*AW +: AW] - AW'(1);
        end
    end

    // tick is registered one cycle early so it is high exactly while the
    // counter's low bits are all ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= ((cnt_nxt & div_mask) == div_mask);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rd_req    <= 1'b0;
            rd_ch     <= '0;
            rd_addr   <= '0;
            wcnt      <= '0;
            data_q    <= '0;
            discard   <= 1'b0;
            fidx      <= '0;
            disp_data <= '0;
            disp_upd  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            disp_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && run && !anim_en) begin
                        state   <= REQ;
                        rd_req  <= 1'b1;
                        rd_ch   <= ch_clamp;
                        rd_addr <= ptr[ch_clamp[CW-1:0]];
                        discard <= 1'b0;
                    end
                end
                REQ: begin
                    if (anim_en) begin
                        discard <= 1'b1;
                    end
                    wcnt <= '0;
                    if (rd_ack) begin
                        data_q <= rd_data;
                        rd_req <= 1'b0;
                        state  <= SHOW;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (anim_en) begin
                        discard <= 1'b1;
                    end
                    if (rd_ack) begin
                        data_q <= rd_data;
                        rd_req <= 1'b0;
                        state  <= SHOW;
                    end else if (wcnt == WLAST) begin
                        data_q <= TMO_DATA;
                        rd_req <= 1'b0;
                        state  <= SHOW;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                end
                SHOW: begin
                    // A transaction overtaken by animation still consumes its entry.
                    if (!discard && !anim_en) begin
                        disp_data <= {4'h0, rd_ch, {(24-AW){1'b0}}, rd_addr, data_q};
                        disp_upd  <= 1'b1;
                    end
                    ptr[cur] <= (ptr[cur] >= depth_m1[cur]) ? '0 : ptr[cur] + AW'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (tick && run && anim_en) begin
                disp_data <= frame_data;
                disp_upd  <= 1'b1;
                fidx      <= (fidx == FLAST) ? '0 : fidx + FW'(1);
            end

            if (clr_ptr) begin
                fidx <= '0;
                for (int i = 0; i < NCH; i++) begin
                    ptr[i] <= '0;
                end
            end
        end
    end

endmodule

// File: doc/dbg_scan_480.md
# dbg_scan_480

Parametrised debug-view sequencer for the single-cycle CPU board top. It generates the slow display tick from the board clock and walks NCH debug channels (register file, ALU taps, data memory, etc.) entry by entry, fetching each entry through a request/acknowledge port. It also plays back a frame-animation sequence from an external frame ROM. Its 64-bit output feeds the 7-segment driver and replaces the ad-hoc per-source scan counters in the top level.

## Interface
- NCH, 4: number of debug channels (2..16)
- AW, 5: entry address width per channel
- FRAMES, 48: animation frame count (≤ 2^FW)
- FW, 6: frame index width
- DIV_FAST, 24: tick period exponent, fast mode (period 2^DIV_FAST clk)
- DIV_SLOW, 27: tick period exponent, slow mode
- TMO, 15: max cycles waiting for rd_ack

- clk  in  1  board clock
- rstn  in  1  asynchronous, active-low reset
- run  in  1  1 = scanning/animation advances on tick
- slow  in  1  selects DIV_SLOW (1) or DIV_FAST (0)
- anim_en  in  1  1 = animation mode, 0 = channel scan mode
- ch_sel  in  4  channel to scan; values ≥ NCH are clamped to NCH-1
- ch_depth  in  NCH*AW  per-channel entry count, channel i at [i*AW +: AW]; 0 treated as 1
- clr_ptr  in  1  synchronous pulse: all entry pointers and frame index to 0
- rd_req  out  1  read request
- rd_ch  out  4  channel of request
- rd_addr  out  AW  entry address of request
- rd_ack  in  1  read complete; rd_data valid this cycle
- rd_data  in  32  entry data
- frame_addr  out  FW  frame ROM address (combinational ROM)
- frame_data  in  64  frame pattern
- tick  out  1  one-cycle pulse per tick period
- disp_data  out  64  display word
- disp_upd  out  1  one-cycle pulse when disp_data changes

## Operation
- Divider: 32-bit free counter. tick = 1 for the cycle where counter[DIV-1:0] is all ones (DIV per slow). Changing slow takes effect immediately; no counter reset.
- FSM states IDLE, REQ, WAIT, SHOW (scan mode only).
  - IDLE: on tick with run=1, anim_en=0 → REQ; latch clamped ch_sel into cur_ch.
  - REQ: rd_req=1, rd_ch=cur_ch, rd_addr=ptr[cur_ch]. If rd_ack in the same cycle → SHOW, else → WAIT.
  - WAIT: rd_req held at 1 with stable rd_ch/rd_addr. rd_ack → SHOW. After TMO WAIT cycles without ack → SHOW with data 32'hDEADDEAD.
  - SHOW: single cycle. disp_data = {cur_ch zero-extended to 8 b, rd_addr zero-extended to 24 b, data}. disp_upd=1. ptr[cur_ch] = (ptr == depth-1) ? 0 : ptr+1. → IDLE.
- Captured data is the rd_data value sampled at the ack edge.
- Pointers are per channel and retained across channel switches; a switched-to channel resumes at its own pointer.
- A depth reduced below the current pointer wraps to 0 at the next advance.
- Ticks arriving outside IDLE are dropped (no queuing).
- Animation: with anim_en=1 and run=1, each tick sets disp_data = frame_data at frame_addr = fidx, then fidx = (fidx == FRAMES-1) ? 0 : fidx+1. disp_upd=1 the cycle after the tick.
- anim_en asserted in REQ/WAIT: the transaction completes or times out. Its data is discarded (no disp_data write, no disp_upd), but the pointer still advances. The FSM then returns to IDLE.
- run=0: ticks still pulse; nothing advances; disp_data holds.
- clr_ptr has priority over any same-cycle advance. It does not abort an in-flight request.

## Timing
- Reset values: counter 0, state IDLE, all ptr 0, fidx 0, rd_req 0, rd_ch 0, rd_addr 0, tick 0, disp_data 64'h0, disp_upd 0. frame_addr = fidx = 0.
- Reset mid-transaction drops rd_req asynchronously. The source must tolerate an abandoned request.
- Latency with zero-wait ack: tick (cycle t) → rd_req (t+1) → SHOW (t+2) → disp_data/disp_upd visible (t+3).
- With ack after k WAIT cycles: disp_data updates k+3 cycles after the tick.
- Timeout: disp_data shows DEADDEAD TMO+3 cycles after the tick.
- Animation: disp_data updates one cycle after tick.
- All outputs registered except frame_addr (direct from fidx).

## Test plan
- Reset, DIV_FAST=4, run=1, ch_sel=1, depth1=3, ack same cycle with rd_data=addr+0x100 → disp_data sequence 0x01000000_00000100, 0x01000001_00000101, 0x01000002_00000102, then wraps to addr 0; tick every 16 clk.
- Ack delayed 5 cycles → rd_req held 6 cycles with stable addr; disp_upd 8 cycles after tick. No ack → disp_data low word 0xDEADDEAD after TMO+3 cycles.
- Scan ch0 to ptr 2, switch to ch2 for 1 entry, back to ch0 → ch0 resumes at addr 2; ch2 ptr = 1.
- anim_en=1, FRAMES=48, frame ROM returns index-tagged patterns → 48 ticks step frames 0..47, then frame 0. Toggle anim_en during WAIT → no disp_upd for that request, pointer +1.
- clr_ptr on the same cycle as SHOW → ptr 0; ch_sel=15 with NCH=4 → rd_ch=3; depth=0 → addr stays 0.
- Assert rstn low during WAIT → rd_req=0 and disp_data=0 immediately; after release the first request uses addr 0.
